// File: rtl/instruction_cache_controller_if.sv
// Fetch-side (PC/INSTRUCTION) and memory-side (block fill) signals of the
// direct-mapped instruction cache, bundled as one bus.
interface instruction_cache_controller_if #(
    parameter int WORDS = 4
);
    localparam int ADDR_W = 30 - $clog2(WORDS);

    logic [31:0]         PC;
    logic                READ;
    logic [31:0]         INSTRUCTION;
    logic                BUSYWAIT;
    logic                MEM_READ;
    logic [ADDR_W-1:0]   MEM_ADDRESS;
    logic [32*WORDS-1:0] MEM_READDATA;
    logic                MEM_BUSYWAIT;

    modport slave (
        input  PC, READ, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output PC, READ, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache with an IDLE/FETCH/UPDATE fill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache_controller #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
`ifdef ICACHE_STATS_EN
    output logic [31:0] HIT_COUNT,
    output logic [31:0] MISS_COUNT,
`endif
    instruction_cache_controller_if.slave bus
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int ADDR_W = 30 - OFF_W;
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES][WORDS];
    logic [ADDR_W-1:0] miss_addr_q;
    logic              mem_read_q;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              unused_pc_lsbs;

    assign pc_off         = bus.PC[OFF_W+1:2];
    assign pc_idx         = bus.PC[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag         = bus.PC[31:OFF_W+IDX_W+2];
    assign unused_pc_lsbs = ^bus.PC[1:0];

    // The fill is steered only by the address captured at the miss, so PC may move freely.
    assign fill_idx = miss_addr_q[IDX_W-1:0];
    assign fill_tag = miss_addr_q[ADDR_W-1:IDX_W];

    logic lookup_hit;
    logic hit;
    logic miss;
    logic fill;

    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit        = !RESET && (state_q == IDLE) && bus.READ && lookup_hit;
    assign miss       = !RESET && (state_q == IDLE) && bus.READ && !lookup_hit;
    assign fill       = !RESET && (state_q == FETCH) && !bus.MEM_BUSYWAIT;

    assign bus.INSTRUCTION = hit ? data_q[pc_idx][pc_off] : NOP;
    assign bus.BUSYWAIT    = miss || (!RESET && (state_q != IDLE));
    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_ADDRESS = miss_addr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_read_q  <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        miss_addr_q <= bus.PC[31:OFF_W+2];
                        mem_read_q  <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (fill) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_read_q        <= 1'b0;
                        state_q           <= UPDATE;
                    end
                end
                UPDATE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags and data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx] <= fill_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_q[fill_idx][w] <= bus.MEM_READDATA[32*w +: 32];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (hit && (HIT_COUNT != 32'hFFFF_FFFF)) begin
                HIT_COUNT <= HIT_COUNT + 32'd1;
            end
            if (miss && (MISS_COUNT != 32'hFFFF_FFFF)) begin
                MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for instruction_cache_controller: stimulus pushes expected
// words/stall lengths and fill addresses, a monitor pops and compares them.
module tb_instruction_cache_controller;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instruction_cache_controller_if #(.WORDS(4)) ifc ();

    instruction_cache_controller #(.LINES(8), .WORDS(4)) dut (
        .CLK        (clk),
        .RESET      (rst),
`ifdef ICACHE_STATS_EN
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count),
`endif
        .bus        (ifc)
    );

    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    exp_t        exp_q [$];
    logic [27:0] addr_q [$];

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 5;
    int mem_cnt;
    int stall_cnt = 0;
    logic        mr_prev = 1'b0;
    logic [27:0] ma_prev = '0;

    // Reference: which 16-byte block each of the 8 lines holds.
    logic        ref_v   [8];
    logic [27:0] ref_blk [8];
    int          hits_m = 0;
    int          miss_m = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return byte_addr ^ 32'hC0DE_0000;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        ifc.MEM_READDATA = '0;
        for (int w = 0; w < 4; w++) begin
            logic [31:0] wi;
            wi = w;
            ifc.MEM_READDATA[32*w +: 32] = mem_word({ifc.MEM_ADDRESS, wi[1:0], 2'b00});
        end
    end

    // Memory: ready in the mem_lat-th cycle of a request.
    initial begin
        ifc.MEM_BUSYWAIT = 1'b1;
        mem_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.MEM_READ) begin
                mem_cnt++;
                ifc.MEM_BUSYWAIT = (mem_cnt != mem_lat);
            end else begin
                mem_cnt = 0;
                ifc.MEM_BUSYWAIT = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
        end else begin
            if (ifc.READ && ifc.BUSYWAIT) begin
                stall_cnt++;
            end else if (ifc.READ) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery actual=%h required=none", ifc.INSTRUCTION);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instruction", ifc.INSTRUCTION, e.instr);
                    check("busywait_cycles", stall_cnt, e.stall);
                end
                stall_cnt = 0;
            end
            if (ifc.MEM_READ && !mr_prev) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_read actual_addr=%h required=no_request", ifc.MEM_ADDRESS);
                end else begin
                    check("mem_address", {4'h0, ifc.MEM_ADDRESS}, {4'h0, addr_q.pop_front()});
                end
            end else if (ifc.MEM_READ && mr_prev) begin
                check("mem_address_stable", {4'h0, ifc.MEM_ADDRESS}, {4'h0, ma_prev});
            end
        end
        mr_prev = ifc.MEM_READ;
        ma_prev = ifc.MEM_ADDRESS;
    end

    task automatic model_access(input logic [31:0] pc, output logic hit);
        logic [27:0] blk;
        blk = pc[31:4];
        hit = ref_v[blk[2:0]] && (ref_blk[blk[2:0]] == blk);
        if (!hit) begin
            addr_q.push_back(blk);
            ref_v[blk[2:0]]   = 1'b1;
            ref_blk[blk[2:0]] = blk;
            miss_m++;
        end
    endtask

    task automatic wait_delivery(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ifc.BUSYWAIT) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=delivery", name);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic fetch(input logic [31:0] pc, input int lat);
        logic h;
        exp_t e;
        mem_lat = lat;
        model_access(pc, h);
        hits_m++;
        e.instr = mem_word({pc[31:2], 2'b00});
        e.stall = h ? 0 : lat + 2;
        exp_q.push_back(e);
        ifc.PC   = pc;
        ifc.READ = 1'b1;
        wait_delivery("fetch");
    endtask

    task automatic fetch_change(input logic [31:0] pc1, input logic [31:0] pc2,
                                input int lat, input int after);
        logic h;
        exp_t e;
        mem_lat = lat;
        model_access(pc1, h);
        e.stall = h ? 0 : lat + 2;
        model_access(pc2, h);
        if (!h) e.stall += lat + 2;
        hits_m++;
        e.instr = mem_word({pc2[31:2], 2'b00});
        exp_q.push_back(e);
        ifc.PC   = pc1;
        ifc.READ = 1'b1;
        repeat (after) begin
            @(posedge clk);
            #2;
        end
        ifc.PC = pc2;
        wait_delivery("pc_change");
    endtask

    task automatic idle_check(input logic [31:0] pc);
        ifc.READ = 1'b0;
        ifc.PC   = pc;
        @(negedge clk);
        check("read0_instruction", ifc.INSTRUCTION, NOP);
        check("read0_busywait", {31'h0, ifc.BUSYWAIT}, 32'h0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_counters(input string name);
`ifdef ICACHE_STATS_EN
        check({name, "_hits"}, hit_count, hits_m);
        check({name, "_misses"}, miss_count, miss_m);
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ref_v[i]   = 1'b0;
            ref_blk[i] = '0;
        end
        rst      = 1'b1;
        ifc.READ = 1'b1;
        ifc.PC   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busywait", {31'h0, ifc.BUSYWAIT}, 32'h0);
        check("reset_mem_read", {31'h0, ifc.MEM_READ}, 32'h0);
        check("reset_instruction", ifc.INSTRUCTION, NOP);
        check("reset_mem_address", {4'h0, ifc.MEM_ADDRESS}, 32'h0);
        check_counters("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Cold miss then same-block hits on consecutive cycles.
        fetch(32'h0, 5);
        fetch(32'h4, 5);
        fetch(32'h8, 5);
        fetch(32'hC, 5);
        check_counters("same_block");

        // Conflict on index 0.
        fetch(32'h80, 3);
        fetch(32'h0, 2);
        check_counters("conflict");

        // READ low over a valid line.
        idle_check(32'h0);
        check_counters("read0");

        fetch_change(32'h40, 32'h100, 4, 2);
        check_counters("pc_change");

        // Reset asserted in the third FETCH cycle.
        ifc.PC   = 32'h200;
        ifc.READ = 1'b1;
        mem_lat  = 5;
        addr_q.push_back(28'h20);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        rst      = 1'b1;
        ifc.READ = 1'b0;
        @(negedge clk);
        check("mid_fill_mem_read", {31'h0, ifc.MEM_READ}, 32'h1);
        check("mid_fill_reset_busywait", {31'h0, ifc.BUSYWAIT}, 32'h0);
        check("mid_fill_reset_instruction", ifc.INSTRUCTION, NOP);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_v[i] = 1'b0;
        hits_m = 0;
        miss_m = 0;
        @(negedge clk);
        check("after_reset_mem_read", {31'h0, ifc.MEM_READ}, 32'h0);
        @(posedge clk);
        #2;
        check_counters("after_reset");
        fetch(32'h200, 5);
        check_counters("refetch");

        // Randomised fetches over 24 blocks, so indices wrap and evict.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 23) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) idle_check(pc);
            fetch(pc, $urandom_range(1, 6));
        end
        check_counters("random");

        ifc.READ = 1'b0;
        repeat (3) @(negedge clk);
        check("pending_deliveries", exp_q.size(), 32'h0);
        check("pending_fills", addr_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
